// File: rtl/swbox_cfg_loader.sv
// Serial configuration loader for one SwitchBox: shifts a 64-bit frame plus an
// even-parity bit into a shadow register and commits it atomically to SRAM.
module swbox_cfg_loader #(
   parameter int CFG_W = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic             cfg_bit,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic [0:CFG_W-1] SRAM,
   output logic             cfg_done,
   output logic             cfg_err,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, COMMIT} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_W - 1);

   state_t           state;
   state_t           state_nxt;
   logic [0:CFG_W-1] shadow;
   logic [CNT_W-1:0] count;
   logic             parity;
   logic             beat;
   logic             restart;
   logic             parity_bad;

   assign beat       = cfg_valid && cfg_ready;
   // A start during COMMIT is ignored so the commit can never be torn.
   assign restart    = cfg_start && (state != COMMIT);
   assign parity_bad = parity ^ cfg_bit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cfg_start) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (cfg_start) begin
               state_nxt = SHIFT;
            end else if (beat && (count == LAST)) begin
               state_nxt = PARITY;
            end
         end
         PARITY: begin
            if (cfg_start) begin
               state_nxt = SHIFT;
            end else if (beat) begin
               state_nxt = parity_bad ? IDLE : COMMIT;
            end
         end
         COMMIT: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      cfg_ready = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE:    busy      = 1'b0;
         SHIFT:   cfg_ready = 1'b1;
         PARITY:  cfg_ready = 1'b1;
         default: cfg_ready = 1'b0;
      endcase
   end

   // Frame assembly and commit; SRAM only moves in COMMIT or reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         SRAM     <= '0;
         shadow   <= '0;
         count    <= '0;
         parity   <= 1'b0;
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_done <= (state == COMMIT);
         if (state == COMMIT) begin
            SRAM <= shadow;
         end
         if (restart) begin
            count   <= '0;
            parity  <= 1'b0;
            cfg_err <= 1'b0;
         end else if (beat && (state == SHIFT)) begin
            for (int i = 0; i < CFG_W; i++) begin
               if (count == CNT_W'(i)) shadow[i] <= cfg_bit;
            end
            parity <= parity ^ cfg_bit;
            if (count != LAST) begin
               count <= count + CNT_W'(1);
            end
         end else if (beat && (state == PARITY) && parity_bad) begin
            cfg_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_swbox_cfg_loader.sv
// Directed self-checking bench for swbox_cfg_loader: reset, good/bad frames,
// stalled transfer, restart, start during commit and reset mid-frame.
module tb_swbox_cfg_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_start;
   logic        cfg_bit;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [0:63] sram;
   logic        cfg_done;
   logic        cfg_err;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   localparam logic [0:63] PAT_A = 64'hF000_0000_0000_0001;
   localparam logic [0:63] PAT_B = 64'hAAAA_5555_AAAA_5555;

   swbox_cfg_loader #(.CFG_W(64), .CNT_W(7)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_start (cfg_start),
      .cfg_bit   (cfg_bit),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .SRAM      (sram),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Start edge S, then SRAM[0] first, then the parity bit. edges_to_done counts
   // edges from S to the first cfg_done (0 if none within the window).
   task automatic run_frame(input logic [0:63] d, input logic p, input bit stall,
                            input bit start_in_commit, output int edges_to_done,
                            output int done_pulses, output logic busy_at_done);
      int n   = 0;
      int idx = 0;
      edges_to_done = 0;
      done_pulses   = 0;
      busy_at_done  = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b1;
      cfg_valid = 1'b0;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      while (idx < 65 && n < 400) begin
         cfg_valid = (!stall) || (((n + 1) % 2) == 0);
         cfg_bit   = (idx < 64) ? d[idx] : p;
         if (cfg_valid && cfg_ready) idx++;
         @(posedge clk); n++; #1;
      end
      cfg_valid = 1'b0;
      cfg_bit   = 1'b0;
      checks++;
      if (idx !== 65) begin
         failures++;
         $display("FAIL frame_bits_accepted: got %0d required 65", idx);
      end
      for (int k = 0; k < 5; k++) begin
         cfg_start = (start_in_commit && k == 0);
         @(posedge clk); n++; #1;
         cfg_start = 1'b0;
         if (cfg_done === 1'b1) begin
            done_pulses++;
            if (edges_to_done == 0) begin
               edges_to_done = n;
               busy_at_done  = busy;
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; cfg_start = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (sram !== 64'h0) begin failures++; $display("FAIL reset_sram: got %h required %h", sram, 64'h0); end
      checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b required 0", cfg_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b required 0", cfg_err); end
      checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", cfg_done); end
      // valid without start must be ignored in IDLE
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      repeat (3) @(posedge clk);
      #1; cfg_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_ignore_valid: busy got %b required 0", busy); end
   endtask

   task automatic test_good_frame;
      int e, pc; logic b;
      run_frame(PAT_A, 1'b1, 1'b0, 1'b0, e, pc, b);
      checks++; if (e !== 66) begin failures++; $display("FAIL good_latency: got %0d required 66", e); end
      checks++; if (pc !== 1) begin failures++; $display("FAIL good_done_pulses: got %0d required 1", pc); end
      checks++; if (sram !== PAT_A) begin failures++; $display("FAIL good_sram: got %h required %h", sram, PAT_A); end
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL good_err: got %b required 0", cfg_err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL good_busy_after: got %b required 0", busy); end
   endtask

   task automatic test_bad_parity;
      int e, pc; logic b;
      run_frame(PAT_B, 1'b1, 1'b0, 1'b0, e, pc, b);
      checks++; if (pc !== 0) begin failures++; $display("FAIL bad_done_pulses: got %0d required 0", pc); end
      checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL bad_err: got %b required 1", cfg_err); end
      checks++; if (sram !== PAT_A) begin failures++; $display("FAIL bad_sram_kept: got %h required %h", sram, PAT_A); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bad_busy: got %b required 0", busy); end
      @(posedge clk); #1;
      cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL bad_err_cleared: got %b required 0", cfg_err); end
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL bad_restart_ready: got %b required 1", cfg_ready); end
   endtask

   task automatic test_stalls;
      int e, pc; logic b;
      run_frame(PAT_A, 1'b1, 1'b1, 1'b0, e, pc, b);
      checks++; if (e !== 131) begin failures++; $display("FAIL stall_latency: got %0d required 131", e); end
      checks++; if (pc !== 1) begin failures++; $display("FAIL stall_done_pulses: got %0d required 1", pc); end
      checks++; if (sram !== PAT_A) begin failures++; $display("FAIL stall_sram: got %h required %h", sram, PAT_A); end
   endtask

   task automatic test_restart;
      int e, pc; logic b;
      @(posedge clk); #1;
      cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      repeat (30) @(posedge clk);
      #1; cfg_valid = 1'b0;
      run_frame(PAT_B, 1'b0, 1'b0, 1'b0, e, pc, b);
      checks++; if (sram !== PAT_B) begin failures++; $display("FAIL restart_sram: got %h required %h", sram, PAT_B); end
      checks++; if (e !== 66) begin failures++; $display("FAIL restart_latency: got %0d required 66", e); end
      checks++; if (pc !== 1) begin failures++; $display("FAIL restart_done_pulses: got %0d required 1", pc); end
   endtask

   task automatic test_start_in_commit;
      int e, pc; logic b;
      run_frame(PAT_A, 1'b1, 1'b0, 1'b1, e, pc, b);
      checks++; if (pc !== 1) begin failures++; $display("FAIL commit_start_pulses: got %0d required 1", pc); end
      checks++; if (b !== 1'b0) begin failures++; $display("FAIL commit_start_busy: got %b required 0", b); end
      checks++; if (sram !== PAT_A) begin failures++; $display("FAIL commit_start_sram: got %h required %h", sram, PAT_A); end
      // leave PAT_B committed for the mid-frame reset scenario
      run_frame(PAT_B, 1'b0, 1'b0, 1'b0, e, pc, b);
      checks++; if (sram !== PAT_B) begin failures++; $display("FAIL recommit_sram: got %h required %h", sram, PAT_B); end
   endtask

   task automatic test_reset_mid_frame;
      @(posedge clk); #1;
      cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midframe_busy: got %b required 1", busy); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      cfg_valid = 1'b0;
      checks++; if (sram !== 64'h0) begin failures++; $display("FAIL midreset_sram: got %h required %h", sram, 64'h0); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b required 0", busy); end
      checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL midreset_ready: got %b required 0", cfg_ready); end
      checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL midreset_done: got %b required 0", cfg_done); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_parity();
      test_stalls();
      test_restart();
      test_start_in_commit();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
